// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the MEM-stage data memory responder.
package dmem_pkg;

   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned RDATA_W = 32;
   localparam int unsigned WDATA_W = 64;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned IDX_W   = 3;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'b00,
      SZ_HALF  = 2'b01,
      SZ_WORD  = 2'b10,
      SZ_DWORD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_XFER = 2'b10,
      ST_DONE = 2'b11
   } state_e;

   // Number of bytes moved by an access of the given size.
   function automatic logic [CNT_W-1:0] size_bytes(input size_e sz);
      case (sz)
         SZ_BYTE:  size_bytes = 4'd1;
         SZ_HALF:  size_bytes = 4'd2;
         SZ_WORD:  size_bytes = 4'd4;
         default:  size_bytes = 4'd8;
      endcase
   endfunction

endpackage

// File: rtl/dmem_array_256x8.sv
// Byte-wide storage: asynchronous read, synchronous write, never reset.
module dmem_array_256x8 #(
   parameter int unsigned DEPTH = 256
) (
   input  logic       i_clk,
   input  logic       i_we,
   input  logic [7:0] i_addr,
   input  logic [7:0] i_wdata,
   output logic [7:0] o_rdata
);

   logic [7:0] Mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) Mem[i_addr] <= i_wdata;
   end

   assign o_rdata = Mem[i_addr];

endmodule

// File: rtl/data_mem_responder.sv
// Byte-serial MEM-stage responder with optional wait states and big-endian byte order.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned requests with an error response.
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned MEM_DEPTH   = 256
) (
   input  logic         CLK,
   input  logic         CLR,
   input  logic         Req_Valid,
   output logic         Req_Ready,
   input  logic         Req_RW,
   input  logic [1:0]   Req_Size,
   input  logic [7:0]   Req_Addr,
   input  logic [63:0]  Req_WData,
   output logic         Rsp_Valid,
   output logic         Rsp_Last,
   output logic [31:0]  Rsp_Data,
   output logic         Rsp_Err
);

   localparam logic [8:0] DEPTH9 = 9'(MEM_DEPTH);

   state_e               r_state;
   logic                 r_ready;
   logic                 r_rw;
   size_e                r_size;
   logic [ADDR_W-1:0]    r_addr;
   logic [WDATA_W-1:0]   r_wdata;
   logic [CNT_W-1:0]     r_wcnt;
   logic [IDX_W-1:0]     r_idx;
   logic [RDATA_W-1:0]   r_asm;
   logic                 r_rsp_valid;
   logic                 r_rsp_last;
   logic [RDATA_W-1:0]   r_rsp_data;

   logic [CNT_W-1:0]     w_nbytes;
   logic                 w_last_byte;
   logic [8:0]           w_sum;
   logic [7:0]           w_mem_addr;
   logic [2:0]           w_shift;
   logic [7:0]           w_wbyte;
   logic [7:0]           w_rbyte;
   logic                 w_we;
   logic [RDATA_W-1:0]   w_asm_next;

   assign w_nbytes    = size_bytes(r_size);
   assign w_last_byte = ({1'b0, r_idx} == (w_nbytes - 4'd1));
   assign w_sum       = {1'b0, r_addr} + {6'b0, r_idx};
   assign w_mem_addr  = 8'(w_sum % DEPTH9);
   // Byte k of an N-byte store sits at bit offset 8*(N-1-k) of the right-justified data.
   assign w_shift     = 3'(w_nbytes - 4'd1) - r_idx;
   assign w_wbyte     = 8'(r_wdata >> {w_shift, 3'b000});
   assign w_we        = (r_state == ST_XFER) && r_rw;
   assign w_asm_next  = {r_asm[23:0], w_rbyte};

   dmem_array_256x8 #(
      .DEPTH   (MEM_DEPTH)
   ) u_mem (
      .i_clk   (CLK),
      .i_we    (w_we),
      .i_addr  (w_mem_addr),
      .i_wdata (w_wbyte),
      .o_rdata (w_rbyte)
   );

`ifdef DMEM_ALIGN_CHECK_EN
   logic r_rsp_err;

   function automatic logic misaligned(input size_e sz, input logic [7:0] a);
      case (sz)
         SZ_BYTE: misaligned = 1'b0;
         SZ_HALF: misaligned = a[0];
         default: misaligned = |a[1:0];
      endcase
   endfunction
`endif

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         r_state     <= ST_IDLE;
         r_ready     <= 1'b1;
         r_rw        <= 1'b0;
         r_size      <= SZ_BYTE;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wcnt      <= '0;
         r_idx       <= '0;
         r_asm       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_last  <= 1'b0;
         r_rsp_data  <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
         r_rsp_err   <= 1'b0;
`endif
      end else begin
         // Response flags are single-cycle pulses.
         r_rsp_valid <= 1'b0;
         r_rsp_last  <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
         r_rsp_err   <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               if (Req_Valid) begin
                  r_ready <= 1'b0;
                  r_rw    <= Req_RW;
                  r_size  <= size_e'(Req_Size);
                  r_addr  <= Req_Addr;
                  r_wdata <= Req_WData;
                  r_idx   <= '0;
                  r_asm   <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
                  if (misaligned(size_e'(Req_Size), Req_Addr)) begin
                     r_state     <= ST_DONE;
                     r_rsp_valid <= 1'b1;
                     r_rsp_last  <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_rsp_data  <= '0;
                  end else
`endif
                  if (WAIT_STATES != 0) begin
                     r_state <= ST_WAIT;
                     r_wcnt  <= 4'(WAIT_STATES);
                  end else begin
                     r_state <= ST_XFER;
                  end
               end
            end
            ST_WAIT: begin
               if (r_wcnt <= 4'd1) begin
                  r_wcnt  <= '0;
                  r_state <= ST_XFER;
               end else begin
                  r_wcnt <= r_wcnt - 4'd1;
               end
            end
            ST_XFER: begin
               if (!r_rw) r_asm <= w_asm_next;
               if (w_last_byte) begin
                  r_state     <= ST_DONE;
                  r_rsp_valid <= 1'b1;
                  r_rsp_last  <= 1'b1;
                  r_rsp_data  <= r_rw ? '0 : w_asm_next;
               end else begin
                  r_idx <= r_idx + 3'd1;
                  // Doubleword loads hand back the first word as soon as it is assembled.
                  if (!r_rw && (r_size == SZ_DWORD) && (r_idx == 3'd3)) begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_data  <= w_asm_next;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign Req_Ready = r_ready;
   assign Rsp_Valid = r_rsp_valid;
   assign Rsp_Last  = r_rsp_last;
   assign Rsp_Data  = r_rsp_data;
`ifdef DMEM_ALIGN_CHECK_EN
   assign Rsp_Err   = r_rsp_err;
`else
   assign Rsp_Err   = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with no wait states, one with three.
module tb_data_mem_responder;

   logic        CLK;
   logic        CLR;
   logic        vld0, vld3;
   logic        Req_RW;
   logic [1:0]  Req_Size;
   logic [7:0]  Req_Addr;
   logic [63:0] Req_WData;

   logic        rdy0, rv0, rl0, re0;
   logic [31:0] rd0;
   logic        rdy3, rv3, rl3, re3;
   logic [31:0] rd3;

   int pass_cnt  = 0;
   int total_cnt = 0;

   data_mem_responder #(.WAIT_STATES(0), .MEM_DEPTH(256)) dut (
      .CLK(CLK), .CLR(CLR), .Req_Valid(vld0), .Req_Ready(rdy0), .Req_RW(Req_RW),
      .Req_Size(Req_Size), .Req_Addr(Req_Addr), .Req_WData(Req_WData),
      .Rsp_Valid(rv0), .Rsp_Last(rl0), .Rsp_Data(rd0), .Rsp_Err(re0)
   );

   data_mem_responder #(.WAIT_STATES(3), .MEM_DEPTH(256)) dut_w3 (
      .CLK(CLK), .CLR(CLR), .Req_Valid(vld3), .Req_Ready(rdy3), .Req_RW(Req_RW),
      .Req_Size(Req_Size), .Req_Addr(Req_Addr), .Req_WData(Req_WData),
      .Rsp_Valid(rv3), .Rsp_Last(rl3), .Rsp_Data(rd3), .Rsp_Err(re3)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Issues one request and records up to two response pulses (cycle 1 = first cycle after acceptance).
   task automatic run_req(input bit sel, input logic rw, input logic [1:0] sz,
                          input logic [7:0] addr, input logic [63:0] wd,
                          output int np, output int c1, output logic [31:0] d1,
                          output logic l1, output logic e1, output int c2,
                          output logic [31:0] d2, output logic l2, output bit rdy_busy);
      logic cr, cv, cl, ce;
      logic [31:0] cd;
      np = 0; c1 = -1; d1 = 'x; l1 = 'x; e1 = 'x; c2 = -1; d2 = 'x; l2 = 'x; rdy_busy = 0;
      @(negedge CLK);
      for (int i = 0; i < 20; i++) begin
         cr = sel ? rdy3 : rdy0;
         if (cr) break;
         @(negedge CLK);
      end
      Req_RW = rw; Req_Size = sz; Req_Addr = addr; Req_WData = wd;
      if (sel) vld3 = 1'b1; else vld0 = 1'b1;
      @(posedge CLK);
      #1 vld0 = 1'b0; vld3 = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge CLK);
         cr = sel ? rdy3 : rdy0;
         cv = sel ? rv3  : rv0;
         cl = sel ? rl3  : rl0;
         ce = sel ? re3  : re0;
         cd = sel ? rd3  : rd0;
         if (cr) rdy_busy = 1;
         if (cv) begin
            np++;
            if (np == 1) begin c1 = c; d1 = cd; l1 = cl; e1 = ce; end
            else begin c2 = c; d2 = cd; l2 = cl; end
            if (cl) break;
         end
      end
   endtask

   task automatic test_reset();
      CLR = 1'b0; vld0 = 1'b0; vld3 = 1'b0;
      Req_RW = 1'b0; Req_Size = 2'b00; Req_Addr = 8'h00; Req_WData = 64'h0;
      #12;
      total_cnt++; if (rdy0 !== 1'b1)  $display("FAIL reset_ready: got %b exp 1", rdy0); else pass_cnt++;
      total_cnt++; if (rv0 !== 1'b0)   $display("FAIL reset_valid: got %b exp 0", rv0); else pass_cnt++;
      total_cnt++; if (rl0 !== 1'b0)   $display("FAIL reset_last: got %b exp 0", rl0); else pass_cnt++;
      total_cnt++; if (rd0 !== 32'h0)  $display("FAIL reset_data: got %h exp 0", rd0); else pass_cnt++;
      total_cnt++; if (re0 !== 1'b0)   $display("FAIL reset_err: got %b exp 0", re0); else pass_cnt++;
      @(negedge CLK); CLR = 1'b1;
   endtask

   task automatic test_word_read();
      int np, c1, c2; logic [31:0] d1, d2; logic l1, e1, l2; bit rb;
      run_req(0, 1'b1, 2'b10, 8'h10, 64'hDEADBEEF, np, c1, d1, l1, e1, c2, d2, l2, rb);
      total_cnt++; if (c1 !== 5 || d1 !== 32'h0) $display("FAIL word_wr_rsp: got cyc %0d data %h exp cyc 5 data 0", c1, d1); else pass_cnt++;
      total_cnt++; if (dut.u_mem.Mem[8'h12] !== 8'hBE) $display("FAIL word_wr_mem12: got %h exp be", dut.u_mem.Mem[8'h12]); else pass_cnt++;
      run_req(0, 1'b0, 2'b10, 8'h10, 64'h0, np, c1, d1, l1, e1, c2, d2, l2, rb);
      total_cnt++; if (c1 !== 5) $display("FAIL word_rd_cycle: got %0d exp 5", c1); else pass_cnt++;
      total_cnt++; if (d1 !== 32'hDEADBEEF) $display("FAIL word_rd_data: got %h exp deadbeef", d1); else pass_cnt++;
      total_cnt++; if (l1 !== 1'b1 || np !== 1) $display("FAIL word_rd_last: got last %b pulses %0d exp 1/1", l1, np); else pass_cnt++;
      total_cnt++; if (rb !== 1'b0) $display("FAIL word_rd_busy_ready: got %b exp 0", rb); else pass_cnt++;
   endtask

   task automatic test_byte_half();
      int np, c1, c2; logic [31:0] d1, d2; logic l1, e1, l2; bit rb;
      run_req(0, 1'b0, 2'b00, 8'h12, 64'h0, np, c1, d1, l1, e1, c2, d2, l2, rb);
      total_cnt++; if (c1 !== 2) $display("FAIL byte_rd_cycle: got %0d exp 2", c1); else pass_cnt++;
      total_cnt++; if (d1 !== 32'h000000BE) $display("FAIL byte_rd_data: got %h exp 000000be", d1); else pass_cnt++;
      run_req(0, 1'b0, 2'b01, 8'h11, 64'h0, np, c1, d1, l1, e1, c2, d2, l2, rb);
`ifdef DMEM_ALIGN_CHECK_EN
      total_cnt++; if (c1 !== 1 || e1 !== 1'b1 || d1 !== 32'h0) $display("FAIL half_misalign_err: got cyc %0d err %b data %h exp 1/1/0", c1, e1, d1); else pass_cnt++;
`else
      total_cnt++; if (c1 !== 3) $display("FAIL half_rd_cycle: got %0d exp 3", c1); else pass_cnt++;
      total_cnt++; if (d1 !== 32'h0000ADBE) $display("FAIL half_rd_data: got %h exp 0000adbe", d1); else pass_cnt++;
      total_cnt++; if (e1 !== 1'b0) $display("FAIL half_rd_err: got %b exp 0", e1); else pass_cnt++;
`endif
   endtask

   task automatic test_dword();
      int np, c1, c2; logic [31:0] d1, d2; logic l1, e1, l2; bit rb;
      run_req(0, 1'b1, 2'b11, 8'h20, 64'h0123456789ABCDEF, np, c1, d1, l1, e1, c2, d2, l2, rb);
      total_cnt++; if (c1 !== 9 || np !== 1 || l1 !== 1'b1) $display("FAIL dw_wr_rsp: got cyc %0d pulses %0d last %b exp 9/1/1", c1, np, l1); else pass_cnt++;
      total_cnt++; if (dut.u_mem.Mem[8'h20] !== 8'h01 || dut.u_mem.Mem[8'h27] !== 8'hEF)
         $display("FAIL dw_wr_mem: got %h %h exp 01 ef", dut.u_mem.Mem[8'h20], dut.u_mem.Mem[8'h27]); else pass_cnt++;
      run_req(0, 1'b0, 2'b11, 8'h20, 64'h0, np, c1, d1, l1, e1, c2, d2, l2, rb);
      total_cnt++; if (np !== 2) $display("FAIL dw_rd_pulses: got %0d exp 2", np); else pass_cnt++;
      total_cnt++; if (c1 !== 5 || l1 !== 1'b0) $display("FAIL dw_rd_first: got cyc %0d last %b exp 5/0", c1, l1); else pass_cnt++;
      total_cnt++; if (d1 !== 32'h01234567) $display("FAIL dw_rd_hi: got %h exp 01234567", d1); else pass_cnt++;
      total_cnt++; if (c2 !== 9 || l2 !== 1'b1) $display("FAIL dw_rd_second: got cyc %0d last %b exp 9/1", c2, l2); else pass_cnt++;
      total_cnt++; if (d2 !== 32'h89ABCDEF) $display("FAIL dw_rd_lo: got %h exp 89abcdef", d2); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int np, c1, c2; logic [31:0] d1, d2; logic l1, e1, l2; bit rb;
      int pulses; logic [31:0] last_data; bit seen_last; bit rdy_seen;
      run_req(0, 1'b1, 2'b00, 8'h60, 64'h0, np, c1, d1, l1, e1, c2, d2, l2, rb);
      @(negedge CLK);
      Req_RW = 1'b0; Req_Size = 2'b10; Req_Addr = 8'h10; vld0 = 1'b1;
      @(posedge CLK);
      #1 vld0 = 1'b0;
      pulses = 0; last_data = '0; seen_last = 0; rdy_seen = 0;
      for (int c = 1; c <= 20 && !seen_last; c++) begin
         @(negedge CLK);
         if (c == 1) begin
            Req_RW = 1'b1; Req_Size = 2'b00; Req_Addr = 8'h60; Req_WData = 64'h99; vld0 = 1'b1;
         end
         if (c == 3) vld0 = 1'b0;
         if (rdy0) rdy_seen = 1;
         if (rv0) begin pulses++; last_data = rd0; seen_last = rl0; end
      end
      vld0 = 1'b0;
      repeat (3) @(negedge CLK);
      total_cnt++; if (pulses !== 1 || last_data !== 32'hDEADBEEF) $display("FAIL ignore_rsp: got pulses %0d data %h exp 1 deadbeef", pulses, last_data); else pass_cnt++;
      total_cnt++; if (rdy_seen !== 1'b0) $display("FAIL ignore_ready: got %b exp 0", rdy_seen); else pass_cnt++;
      total_cnt++; if (dut.u_mem.Mem[8'h60] !== 8'h00) $display("FAIL ignore_mem60: got %h exp 00", dut.u_mem.Mem[8'h60]); else pass_cnt++;
   endtask

   task automatic test_wait_wrap();
      int np, c1, c2; logic [31:0] d1, d2; logic l1, e1, l2; bit rb;
      run_req(1, 1'b1, 2'b00, 8'h00, 64'h77, np, c1, d1, l1, e1, c2, d2, l2, rb);
      total_cnt++; if (c1 !== 5) $display("FAIL w3_byte_wr_cycle: got %0d exp 5", c1); else pass_cnt++;
      run_req(1, 1'b1, 2'b00, 8'hFF, 64'h5A, np, c1, d1, l1, e1, c2, d2, l2, rb);
      total_cnt++; if (dut_w3.u_mem.Mem[8'hFF] !== 8'h5A) $display("FAIL w3_mem_ff: got %h exp 5a", dut_w3.u_mem.Mem[8'hFF]); else pass_cnt++;
      run_req(1, 1'b0, 2'b01, 8'hFF, 64'h0, np, c1, d1, l1, e1, c2, d2, l2, rb);
`ifdef DMEM_ALIGN_CHECK_EN
      total_cnt++; if (c1 !== 1 || e1 !== 1'b1) $display("FAIL w3_half_err: got cyc %0d err %b exp 1/1", c1, e1); else pass_cnt++;
`else
      total_cnt++; if (c1 !== 6) $display("FAIL w3_half_cycle: got %0d exp 6", c1); else pass_cnt++;
      total_cnt++; if (d1 !== 32'h00005A77) $display("FAIL w3_half_data: got %h exp 00005a77", d1); else pass_cnt++;
`endif
      total_cnt++; if (rb !== 1'b0) $display("FAIL w3_busy_ready: got %b exp 0", rb); else pass_cnt++;
   endtask

`ifdef DMEM_ALIGN_CHECK_EN
   task automatic test_align();
      int np, c1, c2; logic [31:0] d1, d2; logic l1, e1, l2; bit rb;
      run_req(0, 1'b1, 2'b10, 8'h02, 64'h11223344, np, c1, d1, l1, e1, c2, d2, l2, rb);
      total_cnt++; if (c1 !== 1 || e1 !== 1'b1 || d1 !== 32'h0 || l1 !== 1'b1)
         $display("FAIL align_wr_err: got cyc %0d err %b data %h last %b exp 1/1/0/1", c1, e1, d1, l1); else pass_cnt++;
      total_cnt++; if (dut.u_mem.Mem[8'h03] === 8'h44) $display("FAIL align_mem_untouched: got %h exp not 44", dut.u_mem.Mem[8'h03]); else pass_cnt++;
      run_req(0, 1'b0, 2'b10, 8'h02, 64'h0, np, c1, d1, l1, e1, c2, d2, l2, rb);
      total_cnt++; if (c1 !== 1 || e1 !== 1'b1 || d1 !== 32'h0) $display("FAIL align_rd_err: got cyc %0d err %b data %h exp 1/1/0", c1, e1, d1); else pass_cnt++;
   endtask
`endif

   task automatic test_reset_abort();
      int np, c1, c2; logic [31:0] d1, d2; logic l1, e1, l2; bit rb;
      run_req(0, 1'b1, 2'b10, 8'h40, 64'h00001122, np, c1, d1, l1, e1, c2, d2, l2, rb);
      @(negedge CLK);
      Req_RW = 1'b1; Req_Size = 2'b10; Req_Addr = 8'h40; Req_WData = 64'hCAFEF00D; vld0 = 1'b1;
      @(posedge CLK);
      #1 vld0 = 1'b0;
      @(posedge CLK);
      @(posedge CLK);
      #1 CLR = 1'b0;
      #1;
      total_cnt++; if (rdy0 !== 1'b1) $display("FAIL abort_ready: got %b exp 1", rdy0); else pass_cnt++;
      total_cnt++; if (rv0 !== 1'b0 || rd0 !== 32'h0) $display("FAIL abort_rsp: got valid %b data %h exp 0/0", rv0, rd0); else pass_cnt++;
      total_cnt++; if (dut.u_mem.Mem[8'h40] !== 8'hCA || dut.u_mem.Mem[8'h41] !== 8'hFE)
         $display("FAIL abort_mem_written: got %h %h exp ca fe", dut.u_mem.Mem[8'h40], dut.u_mem.Mem[8'h41]); else pass_cnt++;
      total_cnt++; if (dut.u_mem.Mem[8'h42] !== 8'h11 || dut.u_mem.Mem[8'h43] !== 8'h22)
         $display("FAIL abort_mem_kept: got %h %h exp 11 22", dut.u_mem.Mem[8'h42], dut.u_mem.Mem[8'h43]); else pass_cnt++;
      @(negedge CLK); CLR = 1'b1;
      run_req(0, 1'b0, 2'b10, 8'h40, 64'h0, np, c1, d1, l1, e1, c2, d2, l2, rb);
      total_cnt++; if (c1 !== 5 || d1 !== 32'hCAFE1122) $display("FAIL abort_next_rd: got cyc %0d data %h exp 5 cafe1122", c1, d1); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_word_read();
      test_byte_half();
      test_dword();
      test_back_to_back();
      test_wait_wrap();
`ifdef DMEM_ALIGN_CHECK_EN
      test_align();
`endif
      test_reset_abort();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 0, wait cycles inserted before the first byte transfer (range 0..15).
REQ-002 SHALL have parameter MEM_DEPTH, default 256, bytes of storage; addresses wrap modulo MEM_DEPTH.
REQ-003 SHALL use one clock and asynchronous active-low reset: CLK  in  1  clock, rising edge.
REQ-004 CLR  in  1  asynchronous reset, active-low.
REQ-005 Req_Valid  in  1  MEM-stage access request.
REQ-006 Req_Ready  out  1  responder idle; request accepted on edge where Req_Valid && Req_Ready.
REQ-007 Req_RW  in  1  1 = write (store), 0 = read (load).
REQ-008 Req_Size  in  2  00 byte, 01 halfword, 10 word, 11 doubleword.
REQ-009 Req_Addr  in  8  byte address.
REQ-010 Req_WData  in  64  store data, right-justified; doubleword uses all 64 bits, first word in [63:32].
REQ-011 Rsp_Valid  out  1  one-cycle response pulse.
REQ-012 Rsp_Last  out  1  qualifies Rsp_Valid as final response of the access.
REQ-013 Rsp_Data  out  32  load data, zero-extended for byte/halfword; 0 for writes.
REQ-014 Rsp_Err  out  1  misaligned-request error, qualified by Rsp_Valid.

Function
REQ-015 SHALL implement states IDLE, WAIT, XFER, DONE; Req_Ready = 1 only in IDLE.
REQ-016 On acceptance, SHALL latch RW/Size/Addr/WData; next state WAIT if WAIT_STATES>0, else XFER.
REQ-017 WAIT SHALL last exactly WAIT_STATES cycles (down-counter), then XFER.
REQ-018 XFER SHALL transfer one byte per cycle, N = 1/2/4/8 bytes for sizes 00/01/10/11, big-endian (lowest address = most significant byte).
REQ-019 Byte address SHALL be Addr+k mod MEM_DEPTH for byte k; wrap past 255 to 0 is legal.
REQ-020 Reads SHALL shift bytes into a 32-bit assembly register; writes SHALL commit one byte per XFER cycle.
REQ-021 After the last XFER byte SHALL enter DONE for one cycle: Rsp_Valid=1, Rsp_Last=1; then IDLE.
REQ-022 Doubleword read SHALL additionally pulse Rsp_Valid=1, Rsp_Last=0 with the first word in the cycle after byte 4, while XFER continues.
REQ-023 Latency from acceptance edge to final Rsp_Valid SHALL be W+N+1 cycles (byte read W=0: cycle 2; word: cycle 5; doubleword: cycles 5 and 9).
REQ-024 Req_Valid while Req_Ready=0 SHALL be ignored, with no queuing.
REQ-025 Read and write of the same byte never overlap; storage SHALL be read-after-write coherent across back-to-back accesses.

Reset
REQ-026 CLR low SHALL asynchronously force IDLE, Req_Ready=1, Rsp_Valid=0, Rsp_Last=0, Rsp_Data=0, Rsp_Err=0, counters 0.
REQ-027 Reset mid-access SHALL abort with no response; bytes already written remain; storage contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro DMEM_ALIGN_CHECK_EN defined: a request whose Addr is not a multiple of its size (doubleword: 4) SHALL skip WAIT/XFER, perform no memory access, and go to DONE with Rsp_Err=1, Rsp_Data=0 in cycle 1.
REQ-029 Macro undefined: no alignment check; Rsp_Err tied 0; misaligned accesses proceed per REQ-019.

Structure
REQ-030 Shared package dmem_pkg SHALL hold size encodings, state encoding, and the size-to-byte-count function.
REQ-031 Storage SHALL be one sub-module dmem_array_256x8 (async read, synchronous byte write) exposing array Mem for testbench preload.

Verification
REQ-032 Preload Mem[0x10..0x13]=DE AD BE EF; word read 0x10, W=0 -> cycle 5 Rsp_Valid, Rsp_Last=1, Rsp_Data=0xDEADBEEF.
REQ-033 Doubleword write 0x20 data 0x0123456789ABCDEF, then doubleword read 0x20 -> pulses 0x01234567 (Last=0) and 0x89ABCDEF (Last=1) at cycles 5 and 9.
REQ-034 WAIT_STATES=3, byte write 0x5A to 0xFF, halfword read 0xFF (macro off) -> Rsp_Data=0x00005A<Mem[0x00]> at cycle 6; no Req_Ready during busy.
REQ-035 With DMEM_ALIGN_CHECK_EN, word read at 0x02 -> cycle 1 Rsp_Valid=1, Rsp_Err=1, Rsp_Data=0, memory unchanged.
REQ-036 Word write 0xCAFEF00D to 0x40, CLR low after 2 XFER cycles -> outputs reset immediately; Mem[0x40]=CA, Mem[0x41]=FE, 0x42/0x43 unchanged; next request accepted normally.
